// File: rtl/a1csa_pkg.sv
// Shared definitions for the add-one carry-select sequential adder.
package a1csa_pkg;

  // Sequencer states: wait for operands, add one slice per cycle, hold result
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_W = 16;
  localparam int DEF_N = 4;

endpackage

// File: rtl/a1csa_slice.sv
// One N-bit add-one carry-select slice: a plain sum with carry-in 0, then
// conditionally incremented when the incoming carry is set.
module a1csa_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         carry_in,
  output logic [N-1:0] result,
  output logic         carry_out
);

  logic [N-1:0] s0;
  logic         c0;

  // The incoming carry can only propagate out of the slice when s0 is all ones
  always_comb begin
    {c0, s0}  = {1'b0, a} + {1'b0, b};
    result    = carry_in ? (s0 + 1'b1) : s0;
    carry_out = c0 | (carry_in & (&s0));
  end

endmodule

// File: rtl/a1csa_seq_ctrl.sv
// Sequential W-bit adder that processes one N-bit slice per cycle through a
// single time-shared add-one carry-select slice, with valid/ready handshakes.
module a1csa_seq_ctrl
  import a1csa_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int N = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         busy
);

  localparam int S  = W / N;
  localparam int KW = (S > 1) ? $clog2(S) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(S - 1);

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic          carry_q, carry_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  sum_q, sum_d;
  logic          cout_q, cout_d;
  logic          in_ready_q, in_ready_d;
  logic          out_valid_q, out_valid_d;
  logic          busy_q, busy_d;

  logic [N-1:0]  slice_a, slice_b, slice_res;
  logic          slice_cout;

  assign slice_a = a_q[k_q*N +: N];
  assign slice_b = b_q[k_q*N +: N];

  a1csa_slice #(.N(N)) u_slice (
    .a         (slice_a),
    .b         (slice_b),
    .carry_in  (carry_q),
    .result    (slice_res),
    .carry_out (slice_cout)
  );

  // Next-state logic: capture operands, walk the slices, then hold until consumed
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[k_q*N +: N] = slice_res;
        carry_d           = slice_cout;
        k_d               = k_q + 1'b1;
        if (k_q == K_LAST) begin
          cout_d  = slice_cout;
          k_d     = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d == RUN);
  end

  // State and registered outputs; reset abandons any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      k_q         <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      carry_q     <= carry_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/a1csa_seq_ctrl.md
A1CSA_SEQ_CTRL -- requirements
Module: a1csa_seq_ctrl

Interface
REQ-001 The block SHALL have parameter W, default 16, meaning total operand width in bits.
REQ-002 The block SHALL have parameter N, default 4, meaning slice width in bits processed per cycle; W SHALL be an integer multiple of N, with W/N >= 2.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; synchronous and active-low.
REQ-005 in_valid  input  1  operand pair and cin are valid.
REQ-006 in_ready  output  1  block can accept an operation.
REQ-007 a, b  input  W  operands.
REQ-008 cin  input  1  carry-in of the operation.
REQ-009 out_valid  output  1  sum and cout are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 sum  output  W  result bits.
REQ-012 cout  output  1  carry-out of the operation.
REQ-013 busy  output  1  high in RUN state.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, in_valid=1 SHALL register a, b and cin, clear slice index k to 0, and go to RUN; otherwise the FSM stays in IDLE.
REQ-018 Each RUN cycle SHALL process slice k (bits k*N+N-1 .. k*N) with the add-one carry-select method:
- p = a_k + b_k with carry-in 0, producing N-bit s0 and carry c0;
- if the carry register is 1, the slice result is s0+1, otherwise s0;
- the new carry is c0 | (carry & (s0 all ones)).
REQ-019 The carry register SHALL be loaded with cin on accept and SHALL hold the carry between slices.
REQ-020 Slice results SHALL be written into the sum register at position k; k SHALL increment by 1 per RUN cycle.
REQ-021 After slice W/N-1 is processed, the FSM SHALL go to DONE and cout SHALL equal the final carry.
REQ-022 Latency: with acceptance at edge E0, out_valid SHALL be 1 after edge E(W/N), i.e. 4 cycles for the defaults.
REQ-023 In DONE, sum and cout SHALL be held stable until out_valid & out_ready; the FSM then returns to IDLE.
REQ-024 No operation SHALL be accepted in the same cycle a result is consumed; in_ready rises the cycle after.
REQ-025 in_valid SHALL be ignored in RUN and DONE; a, b and cin changes after acceptance SHALL have no effect.
REQ-026 The carry SHALL not wrap across operations; every accept reloads it from cin.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set state=IDLE, k=0, carry=0, sum=0 and cout=0.
REQ-028 Reset values of the outputs SHALL be in_ready=1, out_valid=0, busy=0, sum=0 and cout=0.
REQ-029 Reset asserted in RUN or DONE SHALL abort the operation with no result produced; the next operation SHALL start clean.

Structure
REQ-030 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the default constants W=16 and N=4.
REQ-031 The per-slice add-one carry-select logic SHALL be a combinational sub-module a1csa_slice:
- inputs: N-bit a, N-bit b, carry in;
- outputs: N-bit result, carry out.
REQ-032 The sequencer SHALL contain exactly one a1csa_slice instance, time-shared across slices.

Verification
REQ-033 a=0x1234, b=0x4321, cin=0 -> sum=0x5555 and cout=0, with out_valid exactly 4 cycles after accept.
REQ-034 a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000 and cout=1 (add-one ripple through all slices).
REQ-035 a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF and cout=1; a=0x00F0, b=0x0010, cin=0 -> sum=0x0100 and cout=0.
REQ-036 Backpressure: hold out_ready=0 for 3 cycles in DONE while toggling in_valid -> sum and cout stable, in_ready=0, and exactly one result consumed.
REQ-037 Reset mid-RUN: rst_n=0 during the second RUN cycle -> after that edge, in_ready=1, out_valid=0 and sum=0; a following 0x0001+0x0001 with cin=0 -> 0x0002.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> one result every 6 cycles, with in_ready=0 from accept through consume.
